// File: rtl/fifo_traffic_seq.sv
// Traffic-phase sequencer: steps grant_in_ctrl through repeated
// fill / random / drain rounds against the FIFO under test, reacting to the
// FIFO full/empty flags and to per-phase cycle counters with timeout guards.
module fifo_traffic_seq #(
  parameter int unsigned RAND_CYCLES    = 16,
  parameter int unsigned NUM_ROUNDS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned RND_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic [1:0]       grant_in_ctrl,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [RND_W-1:0] round_cnt
);

  localparam int unsigned CNT_MAX = (RAND_CYCLES > TIMEOUT_CYCLES) ? RAND_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] BW_000 = 2'b00;
  localparam logic [1:0] BW_050 = 2'b01;
  localparam logic [1:0] BW_100 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_RANDOM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [RND_W-1:0] round_inc;
  logic             rand_last;
  logic             phase_expired;

  assign round_inc     = round_q + RND_W'(1);
  assign rand_last     = (cnt_q == CNT_W'(RAND_CYCLES - 1));
  assign phase_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state, round/timeout bookkeeping and next-state output decode.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    timeout_d = timeout_q;
    grant_d   = BW_000;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    if (abort) begin
      // Abort keeps the round count so the controller can see how far it got.
      state_d   = S_IDLE;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_FILL;
            round_d   = '0;
            timeout_d = 1'b0;
          end
        end
        S_FILL: begin
          if (fifo_full) begin
            state_d = S_RANDOM;
          end else if (phase_expired) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
        S_RANDOM: begin
          if (rand_last) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            round_d = round_inc;
            state_d = (round_inc == RND_W'(NUM_ROUNDS)) ? S_DONE : S_FILL;
          end else if (phase_expired) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Counter restarts on every state entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    case (state_d)
      S_FILL:   busy_d = 1'b1;
      S_RANDOM: begin
        grant_d = BW_050;
        busy_d  = 1'b1;
      end
      S_DRAIN:  begin
        grant_d = BW_100;
        busy_d  = 1'b1;
      end
      S_DONE:   done_d = 1'b1;
      default:  grant_d = BW_000;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      timeout_q <= 1'b0;
      grant_q   <= BW_000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign grant_in_ctrl = grant_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign round_cnt     = round_q;

endmodule

// File: tb/tb_fifo_traffic_seq.sv
// Bench for fifo_traffic_seq: phase-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fifo_traffic_seq;

  localparam int unsigned RAND = 16;
  localparam int unsigned NUM  = 2;
  localparam int unsigned TO   = 256;
  localparam int unsigned RW   = 8;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          fifo_full  = 1'b0;
  logic          fifo_empty = 1'b0;
  logic [1:0]    grant_in_ctrl;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [RW-1:0] round_cnt;

  int checks = 0;
  int errors = 0;

  fifo_traffic_seq #(
    .RAND_CYCLES    (RAND),
    .NUM_ROUNDS     (NUM),
    .TIMEOUT_CYCLES (TO),
    .RND_W          (RW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .grant_in_ctrl (grant_in_ctrl),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .round_cnt     (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Phase-level model: tracks which phase the run is in and how many whole
  // cycles it has spent there, and applies the phase rules directly.
  typedef enum {M_IDLE, M_FILL, M_RAND, M_DRAIN, M_DONE} mph_e;
  mph_e m_ph     = M_IDLE;
  int   m_len    = 0;
  int   m_rounds = 0;
  bit   m_tmo    = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    mph_e nxt;
    int   cyc;
    int   rnd;
    bit   tmo;
    if (!rst_n) begin
      m_ph     <= M_IDLE;
      m_len    <= 0;
      m_rounds <= 0;
      m_tmo    <= 1'b0;
    end else begin
      nxt = m_ph;
      cyc = m_len + 1;
      rnd = m_rounds;
      tmo = m_tmo;
      if (abort) begin
        nxt = M_IDLE;
        tmo = 1'b0;
      end else begin
        case (m_ph)
          M_IDLE, M_DONE: if (start) begin
            nxt = M_FILL;
            rnd = 0;
            tmo = 1'b0;
          end
          M_FILL: begin
            if (fifo_full) nxt = M_RAND;
            else if (cyc == TO) begin nxt = M_DONE; tmo = 1'b1; end
          end
          M_RAND: if (cyc == RAND) nxt = M_DRAIN;
          M_DRAIN: begin
            if (fifo_empty) begin
              rnd = rnd + 1;
              nxt = (rnd == NUM) ? M_DONE : M_FILL;
            end else if (cyc == TO) begin
              nxt = M_DONE;
              tmo = 1'b1;
            end
          end
          default: nxt = M_IDLE;
        endcase
      end
      m_len    <= (nxt == m_ph) ? cyc : 0;
      m_ph     <= nxt;
      m_rounds <= rnd;
      m_tmo    <= tmo;
    end
  end

  function automatic int exp_grant(input mph_e p);
    return (p == M_RAND) ? 1 : (p == M_DRAIN) ? 2 : 0;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("grant_in_ctrl", int'(grant_in_ctrl), exp_grant(m_ph));
    check("busy", int'(busy), int'(m_ph == M_FILL || m_ph == M_RAND || m_ph == M_DRAIN));
    check("done", int'(done), int'(m_ph == M_DONE));
    check("timeout", int'(timeout), int'(m_tmo));
    check("round_cnt", int'(round_cnt), m_rounds);
  end

  // Run-length monitor: length of the most recent FILL / RANDOM / DRAIN phase.
  int fill_cur = 0, rand_cur = 0, drain_cur = 0;
  int fill_last = 0, rand_last = 0, drain_last = 0;
  always @(negedge clk) begin
    if (busy && grant_in_ctrl == 2'b00) fill_cur <= fill_cur + 1;
    else if (fill_cur != 0) begin fill_last <= fill_cur; fill_cur <= 0; end
    if (grant_in_ctrl == 2'b01) rand_cur <= rand_cur + 1;
    else if (rand_cur != 0) begin rand_last <= rand_cur; rand_cur <= 0; end
    if (grant_in_ctrl == 2'b10) drain_cur <= drain_cur + 1;
    else if (drain_cur != 0) begin drain_last <= drain_cur; drain_cur <= 0; end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start; returns just after FILL has been entered.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One round from FILL entry: full seen after fill_cy cycles, empty after
  // drain_cy DRAIN cycles (0 = never, let DRAIN time out).
  task automatic run_round(input int fill_cy, input int drain_cy);
    repeat (fill_cy - 1) tick();
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    repeat (RAND) tick();
    if (drain_cy == 0) begin
      repeat (TO) tick();
    end else begin
      repeat (drain_cy - 1) tick();
      fifo_empty = 1'b1;
      tick();
      fifo_empty = 1'b0;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(); tick(); #1;
    check("rst grant", int'(grant_in_ctrl), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst timeout", int'(timeout), 0);
    check("rst round", int'(round_cnt), 0);
    rst_n = 1'b1;

    // Two normal rounds 10/16/20; start held during round 2 is ignored.
    tick();
    start_run();
    run_round(10, 20);
    start = 1'b1;
    run_round(10, 20);
    start = 1'b0;
    #1;
    check("t1 done", int'(done), 1);
    check("t1 round", int'(round_cnt), 2);
    check("t1 timeout", int'(timeout), 0);
    check("t1 busy", int'(busy), 0);
    check("t1 grant", int'(grant_in_ctrl), 0);
    check("t1 fill len", fill_last, 10);
    check("t1 rand len", rand_last, 16);
    check("t1 drain len", drain_last, 20);

    // full (and empty) already high at start: 1-cycle FILL, 16-cycle RANDOM.
    fifo_full  = 1'b1;
    fifo_empty = 1'b1;
    start_run();
    tick();
    fifo_full = 1'b0;
    #1;
    check("t2 fill len", fill_last, 1);
    check("t2 grant rand", int'(grant_in_ctrl), 1);
    repeat (RAND) tick();
    #1;
    check("t2 rand len", rand_last, 16);
    check("t2 grant drain", int'(grant_in_ctrl), 2);
    tick();
    fifo_empty = 1'b0;
    #1;
    check("t2 round1", int'(round_cnt), 1);
    check("t2 drain len", drain_last, 1);
    run_round(3, 4);
    #1;
    check("t2 done", int'(done), 1);
    check("t2 round", int'(round_cnt), 2);

    // fifo_full never arrives: FILL times out after 256 cycles.
    start_run();
    repeat (TO - 1) tick();
    #1;
    check("t3 busy before", int'(busy), 1);
    tick();
    #1;
    check("t3 done", int'(done), 1);
    check("t3 timeout", int'(timeout), 1);
    check("t3 round", int'(round_cnt), 0);
    check("t3 grant", int'(grant_in_ctrl), 0);
    check("t3 fill len", fill_last, 256);

    // empty on the same edge as the DRAIN timeout: phase condition wins.
    start_run();
    #1;
    check("t4 restart timeout", int'(timeout), 0);
    check("t4 restart done", int'(done), 0);
    run_round(3, TO);
    #1;
    check("t4 round1", int'(round_cnt), 1);
    check("t4 timeout", int'(timeout), 0);
    check("t4 drain len", drain_last, 256);
    run_round(5, 2);
    #1;
    check("t4 done", int'(done), 1);
    check("t4 round", int'(round_cnt), 2);

    // Abort from DONE clears done but keeps round_cnt.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    check("abort done", int'(done), 0);
    check("abort round held", int'(round_cnt), 2);

    // DRAIN never empties: timeout, round_cnt not incremented.
    start_run();
    run_round(2, 0);
    #1;
    check("drain to done", int'(done), 1);
    check("drain to timeout", int'(timeout), 1);
    check("drain to round", int'(round_cnt), 0);
    check("drain to len", drain_last, 256);

    // Abort with start mid-RANDOM of round 1.
    start_run();
    repeat (3) tick();
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    #1;
    check("t5 grant", int'(grant_in_ctrl), 0);
    check("t5 busy", int'(busy), 0);
    check("t5 done", int'(done), 0);
    check("t5 timeout", int'(timeout), 0);
    tick();
    #1;
    check("t5 still idle", int'(busy), 0);

    // Asynchronous reset mid-DRAIN of round 2, then a fresh run.
    start_run();
    run_round(2, 3);
    tick();
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    repeat (RAND) tick();
    repeat (4) tick();
    #1;
    check("t6 pre round", int'(round_cnt), 1);
    check("t6 pre grant", int'(grant_in_ctrl), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async grant", int'(grant_in_ctrl), 0);
    check("t6 async round", int'(round_cnt), 0);
    check("t6 async busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    start_run();
    run_round(4, 5);
    run_round(4, 5);
    #1;
    check("t6 done", int'(done), 1);
    check("t6 round", int'(round_cnt), 2);
    check("t6 timeout", int'(timeout), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_seq.md
Name: fifo_traffic_seq

Overview:
Synthesizable traffic-phase sequencer that drives the bandwidth-mode selector (grant_in_ctrl) of the FIFO grant_in generator, directly upstream of it. It runs a repeating fill / random / drain schedule against the FIFO under test. Phase changes are triggered by the FIFO full/empty flags and by cycle counters, with per-phase timeout protection. It reports progress, completion and timeout to the bench controller.

Parameters:
RAND_CYCLES, 16, cycles spent in the BW_050 (random) phase per round; legal range >= 1
NUM_ROUNDS, 2, fill/random/drain rounds per run; legal range >= 1
TIMEOUT_CYCLES, 256, maximum cycles allowed in FILL or DRAIN before aborting with timeout; legal range >= 1
RND_W, 8, width of round_cnt; 2**RND_W must be > NUM_ROUNDS

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  run request, sampled on clk; ignored while busy
abort  input  1  synchronous abort, forces return to IDLE
fifo_full  input  1  FIFO full flag
fifo_empty  input  1  FIFO empty flag
grant_in_ctrl  output  2  bandwidth mode: 2'b00=BW_000, 2'b01=BW_050, 2'b10=BW_100; 2'b11 is never driven
busy  output  1  high in FILL, RANDOM and DRAIN
done  output  1  high in DONE
timeout  output  1  sticky timeout flag, valid in DONE
round_cnt  output  RND_W  number of completed rounds

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; grant_in_ctrl=BW_000.
  - busy=0, done=0, timeout=0, round_cnt=0.
  - Internal phase counter = 0.
- All outputs are registered.
  - grant_in_ctrl, busy and done are decoded from next-state, so they change on the same edge as the state.
  - Condition sampled at edge N -> new outputs visible from edge N.
- States and per-state outputs:
  - IDLE: BW_000.
  - FILL: BW_000.
  - RANDOM: BW_050.
  - DRAIN: BW_100.
  - DONE: BW_000.
- Phase counter:
  - Width $clog2(max(RAND_CYCLES,TIMEOUT_CYCLES)+1).
  - Cleared on every state entry; increments each cycle while in a state.
- Transition priority per edge: abort > phase condition > timeout.
- IDLE/DONE + start:
  - Go to FILL.
  - Set round_cnt=0, timeout=0, done=0.
- FILL:
  - fifo_full=1 -> RANDOM.
  - Otherwise, counter==TIMEOUT_CYCLES-1 -> DONE with timeout=1.
  - If fifo_full is already high on entry, FILL lasts exactly 1 cycle.
- RANDOM: exactly RAND_CYCLES cycles (counter==RAND_CYCLES-1 -> DRAIN). FIFO flags are ignored in this state.
- DRAIN:
  - fifo_empty=1 -> increment round_cnt.
  - Then: if round_cnt+1==NUM_ROUNDS -> DONE, else -> FILL.
  - Otherwise, counter==TIMEOUT_CYCLES-1 -> DONE with timeout=1; round_cnt is not incremented.
- DONE:
  - done=1 and round_cnt/timeout are held until the next start (restart) or abort.
- abort in any state:
  - IDLE on the next edge; BW_000.
  - done=0, timeout=0; round_cnt is held.
  - abort together with start -> abort wins, stays IDLE.
- start while busy: no effect.
- Flag handling:
  - Simultaneous fifo_full and fifo_empty: FILL looks only at full, DRAIN looks only at empty.
  - A phase condition and a timeout on the same edge -> the phase condition wins, no timeout.
- Reset mid-run: immediate return to reset values; no partial-round state survives.

Test Plan:
- Reset, then start; fifo_full rises 10 cycles after FILL entry; RANDOM then DRAIN with fifo_empty 20 cycles after DRAIN entry -> grant_in_ctrl sequence 00(10 cy), 01(16 cy), 10(20 cy). Round 2 repeats the same pattern. Then done=1, round_cnt=2, timeout=0, busy=0.
- fifo_full already high at start -> FILL lasts 1 cycle, RANDOM is exactly 16 cycles, grant_in_ctrl=01 for exactly 16 consecutive cycles.
- fifo_full never asserts -> after 256 FILL cycles: done=1, timeout=1, round_cnt=0, grant_in_ctrl=00.
- fifo_empty asserts on the same edge as the DRAIN timeout (counter=255) -> normal round completion, timeout=0.
- abort pulsed mid-RANDOM of round 1 -> next edge IDLE, grant_in_ctrl=00, busy=0, done=0. A start pulse asserted together with abort is ignored.
- rst_n dropped asynchronously mid-DRAIN -> grant_in_ctrl=00 and round_cnt=0 without waiting for a clock edge. A start after release runs a fresh 2-round sequence.
